protocol_tx_scheduler: RTL and testbench

PROTOCOL_TX_SCHEDULER -- requirements
Module: protocol_tx_scheduler

---
 rtl/protocol_tx_scheduler.sv | 95 +++++++++
 tb/tb_protocol_tx_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/protocol_tx_scheduler.sv
// rtl/protocol_tx_scheduler.sv - round-robin transmit scheduler with per-word hold time
module protocol_tx_scheduler #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int COUNT_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [32*NREQ-1:0]         req_data,
  input  logic [NREQ-1:0]            req_mask,
  output logic [NREQ-1:0]            ack,
  output logic                       send_enable,
  output logic [31:0]                send_data,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    last_grant,
  output logic [COUNT_W-1:0]         sent_count
);

  localparam int GW  = $clog2(NREQ);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]     state;
  logic [HCW-1:0] hold_cnt;
  logic [NREQ-1:0] elig;
  logic [GW-1:0]  winner;
  logic [GW-1:0]  cand;
  logic           found;

  // Mask is only consulted here, and this result is only used in IDLE,
  // so mask changes never touch a transfer already in flight.
  assign elig = req & ~req_mask;

  // Round-robin pick: scan upward from the slot after the last grant;
  // the last step (k = NREQ) wraps back onto last_grant itself.
  always_comb begin
    winner = last_grant;
    cand   = last_grant;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_grant + GW'(k);
      if (!found && elig[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Strobes exist only in ISSUE; the granted index is held in last_grant.
  always_comb begin
    send_enable = (state == ISSUE);
    busy        = (state != IDLE);
    ack         = send_enable ? (NREQ'(1) << last_grant) : '0;
  end

  // Scheduler state, latched word, grant history and issue counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      send_data  <= 32'd0;
      last_grant <= GW'(NREQ - 1);
      sent_count <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            send_data  <= req_data[{winner, 5'b0} +: 32];
            last_grant <= winner;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          sent_count <= sent_count + COUNT_W'(1);
          hold_cnt   <= '0;
          state      <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_protocol_tx_scheduler.sv
// tb/tb_protocol_tx_scheduler.sv - directed self-checking bench for protocol_tx_scheduler
module tb_protocol_tx_scheduler;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   req_mask;
  logic [3:0]   ack;
  logic         send_enable;
  logic [31:0]  send_data;
  logic         busy;
  logic [1:0]   last_grant;
  logic [3:0]   sent_count;

  int total  = 0;
  int passed = 0;
  int cyc_n  = 0;

  protocol_tx_scheduler #(.NREQ(4), .HOLD_CYCLES(8), .COUNT_W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .req_mask(req_mask), .ack(ack), .send_enable(send_enable),
    .send_data(send_data), .busy(busy), .last_grant(last_grant),
    .sent_count(sent_count)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_mask = '0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_enable(output int waited);
    waited = 0;
    while (send_enable !== 1'b1 && waited < 30) begin
      cyc();
      waited++;
    end
  endtask

  task automatic test_reset();
    req_data = {32'hD0D0_0003, 32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    reset = 1'b1; req = 4'b1111; req_mask = '0;
    cyc(); cyc();
    total++; if (send_enable !== 1'b0) $display("FAIL reset_enable got=%b exp=0", send_enable); else passed++;
    total++; if (ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", ack); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (send_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", send_data); else passed++;
    total++; if (sent_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", sent_count); else passed++;
    total++; if (last_grant !== 2'd3) $display("FAIL reset_last_grant got=%0d exp=3", last_grant); else passed++;
    reset = 1'b0; req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_data[31:0] = 32'hA5A5_0001;
    req = 4'b0001;
    cyc();
    total++; if (send_enable !== 1'b1) $display("FAIL single_enable got=%b exp=1", send_enable); else passed++;
    total++; if (ack !== 4'b0001) $display("FAIL single_ack got=%b exp=0001", ack); else passed++;
    total++; if (send_data !== 32'hA5A5_0001) $display("FAIL single_data got=%h exp=a5a50001", send_data); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy_issue got=%b exp=1", busy); else passed++;
    req = 4'b0000;
    for (int i = 2; i <= 9; i++) begin
      cyc();
      total++;
      if (send_enable !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1 || send_data !== 32'hA5A5_0001)
        $display("FAIL single_hold t+%0d en=%b ack=%b busy=%b data=%h exp en=0 ack=0000 busy=1 data=a5a50001",
                 i, send_enable, ack, busy, send_data);
      else passed++;
    end
    total++; if (sent_count !== 4'd1) $display("FAIL single_count got=%0d exp=1", sent_count); else passed++;
    cyc();
    total++; if (busy !== 1'b0) $display("FAIL single_busy_end got=%b exp=0", busy); else passed++;
    total++; if (send_data !== 32'hA5A5_0001) $display("FAIL single_data_idle got=%h exp=a5a50001", send_data); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    req_data = {32'hD0D0_0003, 32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    req = 4'b1010;
    cyc();
    total++; if (ack !== 4'b0010) $display("FAIL priority_ack got=%b exp=0010", ack); else passed++;
    total++; if (last_grant !== 2'd1) $display("FAIL priority_grant got=%0d exp=1", last_grant); else passed++;
    req = 4'b0000;
    repeat (10) cyc();
  endtask

  task automatic test_round_robin();
    int waited;
    int prev;
    logic [3:0]  exp_ack;
    logic [31:0] exp_data;
    logic [31:0] words [4];
    words[0] = 32'hA0A0_0000; words[1] = 32'hB0B0_0001;
    words[2] = 32'hC0C0_0002; words[3] = 32'hD0D0_0003;
    do_reset();
    req_data = {words[3], words[2], words[1], words[0]};
    req = 4'b1111;
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      wait_enable(waited);
      total++; if (waited >= 30) $display("FAIL rr_timeout n=%0d waited=%0d limit=30", n, waited); else passed++;
      exp_ack  = 4'b0001 << (n % 4);
      exp_data = words[n % 4];
      total++; if (ack !== exp_ack) $display("FAIL rr_ack n=%0d got=%b exp=%b", n, ack, exp_ack); else passed++;
      total++; if (send_data !== exp_data) $display("FAIL rr_data n=%0d got=%h exp=%h", n, send_data, exp_data); else passed++;
      if (n > 0) begin
        total++; if (cyc_n - prev !== 10) $display("FAIL rr_spacing n=%0d got=%0d exp=10", n, cyc_n - prev); else passed++;
      end
      prev = cyc_n;
      cyc();
    end
    req = 4'b0000;
    repeat (10) cyc();
  endtask

  task automatic test_mask();
    int issues = 0;
    int ack0 = 0;
    int bad = 0;
    do_reset();
    req = 4'b0011; req_mask = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (send_enable === 1'b1) begin
        issues++;
        if (ack !== 4'b0010) bad++;
      end
      if (ack[0] === 1'b1) ack0++;
    end
    total++; if (issues !== 4) $display("FAIL mask_issues got=%0d exp=4", issues); else passed++;
    total++; if (bad !== 0) $display("FAIL mask_ack_value got=%0d wrong exp=0", bad); else passed++;
    total++; if (ack0 !== 0) $display("FAIL mask_ack0 got=%0d exp=0", ack0); else passed++;
    req = 4'b0000; req_mask = 4'b0000;
    repeat (10) cyc();
  endtask

  task automatic test_reset_in_hold();
    int stray = 0;
    do_reset();
    req_data[31:0] = 32'h1234_5678;
    req = 4'b0001;
    cyc();
    req = 4'b0000;
    cyc(); cyc(); cyc();
    total++; if (busy !== 1'b1 || sent_count !== 4'd1) $display("FAIL rsthold_pre busy=%b count=%0d exp busy=1 count=1", busy, sent_count); else passed++;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rsthold_busy got=%b exp=0", busy); else passed++;
    total++; if (sent_count !== 4'd0) $display("FAIL rsthold_count got=%0d exp=0", sent_count); else passed++;
    total++; if (send_data !== 32'h0) $display("FAIL rsthold_data got=%h exp=0", send_data); else passed++;
    total++; if (last_grant !== 2'd3) $display("FAIL rsthold_grant got=%0d exp=3", last_grant); else passed++;
    for (int i = 0; i < 15; i++) begin
      if (send_enable !== 1'b0 || ack !== 4'b0000) stray++;
      cyc();
    end
    total++; if (stray !== 0) $display("FAIL rsthold_stray got=%0d exp=0", stray); else passed++;
  endtask

  task automatic test_count_wrap();
    int waited;
    int timeouts = 0;
    logic [3:0] exp_cnt;
    do_reset();
    req_data[31:0] = 32'hCAFE_0000;
    req = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      wait_enable(waited);
      if (waited >= 30) timeouts++;
      cyc();
      exp_cnt = 4'(k);
      if (k >= 15) begin
        total++;
        if (sent_count !== exp_cnt) $display("FAIL wrap_count word=%0d got=%0d exp=%0d", k, sent_count, exp_cnt);
        else passed++;
      end
    end
    total++; if (timeouts !== 0) $display("FAIL wrap_timeout got=%0d exp=0", timeouts); else passed++;
    req = 4'b0000;
    repeat (10) cyc();
  endtask

  task automatic test_drop_and_mask();
    int extra = 0;
    int held_bad = 0;
    do_reset();
    req_data[95:64] = 32'h2222_BEEF;
    req = 4'b0100;
    cyc();
    total++; if (ack !== 4'b0100 || send_enable !== 1'b1) $display("FAIL drop_issue ack=%b en=%b exp ack=0100 en=1", ack, send_enable); else passed++;
    req = 4'b0000;
    cyc();
    req_mask = 4'b0100;
    req = 4'b0100;
    req_data[95:64] = 32'h3333_0000;
    for (int i = 2; i <= 8; i++) begin
      cyc();
      if (busy !== 1'b1 || send_data !== 32'h2222_BEEF) held_bad++;
    end
    total++; if (held_bad !== 0) $display("FAIL drop_hold got=%0d bad cycles exp=0", held_bad); else passed++;
    total++; if (sent_count !== 4'd1) $display("FAIL drop_count got=%0d exp=1", sent_count); else passed++;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ack[2] === 1'b1 || send_enable === 1'b1) extra++;
    end
    total++; if (extra !== 0) $display("FAIL drop_second_ack got=%0d exp=0", extra); else passed++;
    total++; if (send_data !== 32'h2222_BEEF) $display("FAIL drop_data_idle got=%h exp=2222beef", send_data); else passed++;
    req = 4'b0000; req_mask = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_mask = '0; req_data = '0;
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_mask();
    test_reset_in_hold();
    test_count_wrap();
    test_drop_and_mask();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
